// File: rtl/gry_conflict_monitor.sv
// Safety monitor for the 4-way traffic-light lamp drives: decodes heads and latches the first
// conflict/lamp/pair/sequence/timing fault. Optional entry counter output: GRY_MON_FAULT_CNT_EN.
module gry_conflict_monitor #(
    parameter int CNT_W      = 5,
    parameter int MIN_GREEN  = 4,
    parameter int MIN_YELLOW = 2,
    parameter int MAX_YELLOW = 4
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       a0_green,
    input  logic       a0_yellow,
    input  logic       a0_red,
    input  logic       a1_green,
    input  logic       a1_yellow,
    input  logic       a1_red,
    input  logic       b0_green,
    input  logic       b0_yellow,
    input  logic       b0_red,
    input  logic       b1_green,
    input  logic       b1_yellow,
    input  logic       b1_red,
    input  logic       clr_fault,
    output logic [1:0] a_phase,
    output logic [1:0] b_phase,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       fault_grp,
    output logic       all_red_req
`ifdef GRY_MON_FAULT_CNT_EN
    ,
    output logic [7:0] fault_cnt
`endif
);

    localparam logic [1:0] PH_INV = 2'b00;
    localparam logic [1:0] PH_G   = 2'b01;
    localparam logic [1:0] PH_Y   = 2'b10;
    localparam logic [1:0] PH_R   = 2'b11;

    localparam logic [2:0] C_NONE     = 3'd0;
    localparam logic [2:0] C_CONFLICT = 3'd1;
    localparam logic [2:0] C_LAMP     = 3'd2;
    localparam logic [2:0] C_PAIR     = 3'd3;
    localparam logic [2:0] C_SEQ      = 3'd4;
    localparam logic [2:0] C_TIMING   = 3'd5;
    localparam logic [2:0] C_STUCK    = 3'd6;

    localparam logic [CNT_W-1:0] DWELL_ONE = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] DWELL_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] MIN_G_C   = CNT_W'(MIN_GREEN);
    localparam logic [CNT_W-1:0] MIN_Y_C   = CNT_W'(MIN_YELLOW);
    localparam logic [CNT_W-1:0] MAX_Y_C   = CNT_W'(MAX_YELLOW);

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

    function automatic logic [1:0] head_decode(input logic [2:0] gyr);
        logic [1:0] ph;
        case (gyr)
            3'b100:  ph = PH_G;
            3'b010:  ph = PH_Y;
            3'b001:  ph = PH_R;
            default: ph = PH_INV;
        endcase
        return ph;
    endfunction

    function automatic logic seq_legal(input logic [1:0] from_ph, input logic [1:0] to_ph);
        return ((from_ph == PH_G) && (to_ph == PH_Y)) ||
               ((from_ph == PH_Y) && (to_ph == PH_R)) ||
               ((from_ph == PH_R) && (to_ph == PH_G));
    endfunction

    // Heads are indexed a0, a1, b0, b1; each entry is {green, yellow, red}.
    logic [3:0][2:0]       lamp_q;
    logic                  smp_vld_q;
    logic [3:0][1:0]       head_ph_s;
    logic [3:0]            inv_s;
    logic [1:0][1:0]       grp_ph_q;
    logic [1:0][CNT_W-1:0] dwell_q;
    logic [1:0][CNT_W-1:0] dwell_d;
    logic [1:0]            chg_s;
    logic [1:0]            pair_s;
    logic [1:0]            seq_s;
    logic [1:0]            tim_s;
    logic [1:0]            stuck_s;
    logic                  conflict_s;
    logic                  run_chk_s;
    logic [2:0]            det_code_s;
    logic                  det_grp_s;
    logic                  clr_acc_s;
    logic                  enter_fault_s;

    state_e                state_q;
    state_e                state_d;
    logic                  fault_q;
    logic                  fault_d;
    logic                  all_red_q;
    logic                  all_red_d;
    logic [2:0]            code_q;
    logic [2:0]            code_d;
    logic                  grp_q;
    logic                  grp_d;

    assign clr_acc_s = (state_q == ST_FAULT) && clr_fault;
    assign run_chk_s = (state_q == ST_RUN);

    // Lamp capture; a sample taken alongside an accepted clear is marked unusable.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            lamp_q    <= '0;
            smp_vld_q <= 1'b0;
        end else begin
            lamp_q[0] <= {a0_green, a0_yellow, a0_red};
            lamp_q[1] <= {a1_green, a1_yellow, a1_red};
            lamp_q[2] <= {b0_green, b0_yellow, b0_red};
            lamp_q[3] <= {b1_green, b1_yellow, b1_red};
            smp_vld_q <= !clr_acc_s;
        end
    end

    // Head decode and dwell next-state.
    always_comb begin
        head_ph_s = '0;
        inv_s     = '0;
        dwell_d   = dwell_q;
        for (int h = 0; h < 4; h++) begin
            head_ph_s[h] = head_decode(lamp_q[h]);
            inv_s[h]     = (head_ph_s[h] == PH_INV);
        end
        for (int g = 0; g < 2; g++) begin
            if ((state_q == ST_INIT) || (head_ph_s[2*g] != grp_ph_q[g])) begin
                dwell_d[g] = DWELL_ONE;
            end else if (dwell_q[g] == DWELL_MAX) begin
                dwell_d[g] = DWELL_MAX;
            end else begin
                dwell_d[g] = dwell_q[g] + DWELL_ONE;
            end
        end
    end

    // Per-group rule hits; transitions judge the dwell of the phase being left.
    always_comb begin
        chg_s   = '0;
        pair_s  = '0;
        seq_s   = '0;
        tim_s   = '0;
        stuck_s = '0;
        for (int g = 0; g < 2; g++) begin
            chg_s[g]   = (head_ph_s[2*g] != grp_ph_q[g]);
            pair_s[g]  = (head_ph_s[2*g] != head_ph_s[2*g+1]);
            seq_s[g]   = chg_s[g] && !seq_legal(grp_ph_q[g], head_ph_s[2*g]);
            tim_s[g]   = chg_s[g] &&
                         (((grp_ph_q[g] == PH_G) && (dwell_q[g] < MIN_G_C)) ||
                          ((grp_ph_q[g] == PH_Y) && (dwell_q[g] < MIN_Y_C)));
            stuck_s[g] = (head_ph_s[2*g] == PH_Y) && (dwell_d[g] > MAX_Y_C);
        end
        conflict_s = (head_ph_s[0] != PH_R) && (head_ph_s[2] != PH_R);
    end

    // Priority encode: lowest code first, group A before group B.
    always_comb begin
        det_code_s = C_NONE;
        det_grp_s  = 1'b0;
        if (conflict_s) begin
            det_code_s = C_CONFLICT;
        end else if (|inv_s) begin
            det_code_s = C_LAMP;
            det_grp_s  = !(inv_s[0] || inv_s[1]);
        end else if (pair_s[0]) begin
            det_code_s = C_PAIR;
        end else if (pair_s[1]) begin
            det_code_s = C_PAIR;
            det_grp_s  = 1'b1;
        end else if (run_chk_s && seq_s[0]) begin
            det_code_s = C_SEQ;
        end else if (run_chk_s && seq_s[1]) begin
            det_code_s = C_SEQ;
            det_grp_s  = 1'b1;
        end else if (run_chk_s && tim_s[0]) begin
            det_code_s = C_TIMING;
        end else if (run_chk_s && tim_s[1]) begin
            det_code_s = C_TIMING;
            det_grp_s  = 1'b1;
        end else if (run_chk_s && stuck_s[0]) begin
            det_code_s = C_STUCK;
        end else if (run_chk_s && stuck_s[1]) begin
            det_code_s = C_STUCK;
            det_grp_s  = 1'b1;
        end else begin
            det_code_s = C_NONE;
            det_grp_s  = 1'b0;
        end
    end

    // Monitor FSM next-state and latched fault outputs.
    always_comb begin
        state_d       = state_q;
        fault_d       = fault_q;
        all_red_d     = all_red_q;
        code_d        = code_q;
        grp_d         = grp_q;
        enter_fault_s = 1'b0;
        case (state_q)
            ST_INIT, ST_RUN: begin
                if ((state_q == ST_INIT) && !smp_vld_q) begin
                    state_d = ST_INIT;
                end else if (det_code_s != C_NONE) begin
                    state_d       = ST_FAULT;
                    fault_d       = 1'b1;
                    all_red_d     = 1'b1;
                    code_d        = det_code_s;
                    grp_d         = det_grp_s;
                    enter_fault_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (clr_fault) begin
                    state_d   = ST_INIT;
                    fault_d   = 1'b0;
                    all_red_d = 1'b0;
                    code_d    = C_NONE;
                    grp_d     = 1'b0;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            default: begin
                state_d   = ST_INIT;
                fault_d   = 1'b0;
                all_red_d = 1'b0;
                code_d    = C_NONE;
                grp_d     = 1'b0;
            end
        endcase
    end

    // State, fault, phase and dwell registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_INIT;
            fault_q   <= 1'b0;
            all_red_q <= 1'b0;
            code_q    <= C_NONE;
            grp_q     <= 1'b0;
            grp_ph_q  <= '0;
            dwell_q   <= '0;
        end else begin
            state_q     <= state_d;
            fault_q     <= fault_d;
            all_red_q   <= all_red_d;
            code_q      <= code_d;
            grp_q       <= grp_d;
            grp_ph_q[0] <= head_ph_s[0];
            grp_ph_q[1] <= head_ph_s[2];
            dwell_q     <= dwell_d;
        end
    end

    assign a_phase     = grp_ph_q[0];
    assign b_phase     = grp_ph_q[1];
    assign fault       = fault_q;
    assign fault_code  = code_q;
    assign fault_grp   = grp_q;
    assign all_red_req = all_red_q;

`ifdef GRY_MON_FAULT_CNT_EN
    logic [7:0] fault_cnt_q;

    // Saturating count of fault entries; survives clr_fault.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fault_cnt_q <= 8'd0;
        end else if (enter_fault_s && (fault_cnt_q != 8'hFF)) begin
            fault_cnt_q <= fault_cnt_q + 8'd1;
        end else begin
            fault_cnt_q <= fault_cnt_q;
        end
    end

    assign fault_cnt = fault_cnt_q;
`endif

endmodule

// File: tb/tb_gry_conflict_monitor.sv
// Directed + randomized bench for gry_conflict_monitor against a per-sample rule model.
module tb_gry_conflict_monitor;

    logic       clk = 1'b0;
    logic       rstn;
    logic       a0_green, a0_yellow, a0_red, a1_green, a1_yellow, a1_red;
    logic       b0_green, b0_yellow, b0_red, b1_green, b1_yellow, b1_red;
    logic       clr_fault;
    logic [1:0] a_phase;
    logic [1:0] b_phase;
    logic       fault;
    logic [2:0] fault_code;
    logic       fault_grp;
    logic       all_red_req;
`ifdef GRY_MON_FAULT_CNT_EN
    logic [7:0] fault_cnt;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: phases 0 invalid, 1 G, 2 Y, 3 R.
    int       m_prev[2];
    int       m_dwell[2];
    int       m_exp_ph[2];
    bit       m_fault;
    bit       m_first;
    int       m_code;
    int       m_grp;
    int       m_cnt;
    bit [11:0] cur_p;
    bit       cur_ok;

    gry_conflict_monitor dut (
        .clk(clk), .rstn(rstn),
        .a0_green(a0_green), .a0_yellow(a0_yellow), .a0_red(a0_red),
        .a1_green(a1_green), .a1_yellow(a1_yellow), .a1_red(a1_red),
        .b0_green(b0_green), .b0_yellow(b0_yellow), .b0_red(b0_red),
        .b1_green(b1_green), .b1_yellow(b1_yellow), .b1_red(b1_red),
        .clr_fault(clr_fault),
        .a_phase(a_phase), .b_phase(b_phase),
        .fault(fault), .fault_code(fault_code), .fault_grp(fault_grp),
        .all_red_req(all_red_req)
`ifdef GRY_MON_FAULT_CNT_EN
        , .fault_cnt(fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic int dec(input bit [2:0] l);
        case (l)
            3'b100:  return 1;
            3'b010:  return 2;
            3'b001:  return 3;
            default: return 0;
        endcase
    endfunction

    function automatic bit [2:0] lamp(input int ph);
        case (ph)
            1:       return 3'b100;
            2:       return 3'b010;
            3:       return 3'b001;
            default: return 3'b000;
        endcase
    endfunction

    function automatic bit [11:0] pat(input int a, input int b);
        return {lamp(a), lamp(a), lamp(b), lamp(b)};
    endfunction

    function automatic bit [11:0] stage_pat(input int s);
        case (s)
            0:       return pat(1, 3);
            1:       return pat(2, 3);
            2:       return pat(3, 1);
            default: return pat(3, 2);
        endcase
    endfunction

    function automatic bit legal_edge(input int f, input int t);
        return (f == 1 && t == 2) || (f == 2 && t == 3) || (f == 3 && t == 1);
    endfunction

    function automatic bit rule_hit(input int c, input int prev, input int now,
                                    input int old_d, input int new_d);
        bit moved;
        moved = (prev != now);
        case (c)
            4:       return moved && !legal_edge(prev, now);
            5:       return moved && ((prev == 1 && old_d < 4) || (prev == 2 && old_d < 2));
            default: return (now == 2) && (new_d > 4);
        endcase
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input int exp);
        logic [7:0] e8;
        e8 = 8'(exp);
        tests++;
        assert (obs === e8) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, e8);
        end
    endtask

    task automatic model_reset();
        for (int g = 0; g < 2; g++) begin
            m_prev[g]   = 0;
            m_dwell[g]  = 0;
            m_exp_ph[g] = 0;
        end
        m_fault = 1'b0;
        m_first = 1'b1;
        m_code  = 0;
        m_grp   = 0;
        m_cnt   = 0;
        cur_p   = '0;
        cur_ok  = 1'b0;
    endtask

    // Apply every rule to one captured sample; acc reports an accepted clear.
    task automatic model_eval(input bit [11:0] s, input bit ok, input bit clr, output bit acc);
        int ph[4];
        int nd[2];
        int code;
        int grp;
        acc  = 1'b0;
        code = 0;
        grp  = 0;
        for (int h = 0; h < 4; h++) ph[h] = dec(s[11-3*h -: 3]);
        for (int g = 0; g < 2; g++) begin
            if (m_first || ph[2*g] != m_prev[g]) nd[g] = 1;
            else nd[g] = (m_dwell[g] + 1 > 31) ? 31 : m_dwell[g] + 1;
        end
        if (ph[0] != 3 && ph[2] != 3) code = 1;
        else if (ph[0] == 0 || ph[1] == 0) begin code = 2; grp = 0; end
        else if (ph[2] == 0 || ph[3] == 0) begin code = 2; grp = 1; end
        else if (ph[0] != ph[1]) begin code = 3; grp = 0; end
        else if (ph[2] != ph[3]) begin code = 3; grp = 1; end
        if (code == 0 && !m_first) begin
            for (int c = 4; c <= 6; c++)
                for (int g = 0; g < 2; g++)
                    if (code == 0 && rule_hit(c, m_prev[g], ph[2*g], m_dwell[g], nd[g])) begin
                        code = c;
                        grp  = g;
                    end
        end
        if (m_fault) begin
            if (clr) begin
                m_fault = 1'b0; m_code = 0; m_grp = 0; m_first = 1'b1; acc = 1'b1;
            end
        end else if (m_first && !ok) begin
            m_first = 1'b1;
        end else if (code != 0) begin
            m_fault = 1'b1; m_code = code; m_grp = grp; m_first = 1'b0;
            if (m_cnt < 255) m_cnt++;
        end else begin
            m_first = 1'b0;
        end
        for (int g = 0; g < 2; g++) begin
            m_prev[g]   = ph[2*g];
            m_exp_ph[g] = ph[2*g];
            m_dwell[g]  = nd[g];
        end
    endtask

    task automatic check_all();
        chk("a_phase", {6'd0, a_phase}, m_exp_ph[0]);
        chk("b_phase", {6'd0, b_phase}, m_exp_ph[1]);
        chk("fault", {7'd0, fault}, int'(m_fault));
        chk("all_red_req", {7'd0, all_red_req}, int'(m_fault));
        chk("fault_code", {5'd0, fault_code}, m_code);
        chk("fault_grp", {7'd0, fault_grp}, m_grp);
`ifdef GRY_MON_FAULT_CNT_EN
        chk("fault_cnt", fault_cnt, m_cnt);
`endif
    endtask

    // One clock: drive at the falling edge, check at the next falling edge.
    task automatic step(input bit [11:0] p, input bit clr);
        bit acc;
        model_eval(cur_p, cur_ok, clr, acc);
        {a0_green, a0_yellow, a0_red, a1_green, a1_yellow, a1_red,
         b0_green, b0_yellow, b0_red, b1_green, b1_yellow, b1_red} = p;
        clr_fault = clr;
        cur_p  = p;
        cur_ok = !acc;
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        clr_fault = 1'b0;
        {a0_green, a0_yellow, a0_red, a1_green, a1_yellow, a1_red,
         b0_green, b0_yellow, b0_red, b1_green, b1_yellow, b1_red} = 12'd0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_all();
        rstn = 1'b1;
    endtask

    initial begin
        int        stage;
        int        len;
        bit [11:0] p;

        do_reset();

        // Legal cycle: A G6/Y2/R8, B R8 then G6/Y2.
        for (int i = 0; i < 64; i++) begin
            stage = (i % 16 < 6) ? 0 : (i % 16 < 8) ? 1 : (i % 16 < 14) ? 2 : 3;
            step(stage_pat(stage), 1'b0);
        end
        chk("legal_no_fault", {7'd0, fault}, 0);

        // Both directions green.
        step(pat(1, 1), 1'b0);
        step(pat(3, 3), 1'b0);
        chk("conflict_code", {5'd0, fault_code}, 1);
        chk("conflict_all_red", {7'd0, all_red_req}, 1);
        for (int i = 0; i < 3; i++) step(pat(3, 1), 1'b0);
        chk("conflict_sticky", {7'd0, fault}, 1);

        // Clear with legal inputs, then lamp fault while A jumps G->R.
        step(pat(3, 3), 1'b1);
        chk("clear_fault", {7'd0, fault}, 0);
        step(pat(3, 3), 1'b0);
        for (int i = 0; i < 6; i++) step(pat(1, 3), 1'b0);
        step({3'b110, 3'b001, lamp(3), lamp(3)}, 1'b0);
        step(pat(3, 3), 1'b0);
        chk("lamp_code", {5'd0, fault_code}, 2);
        chk("lamp_grp", {7'd0, fault_grp}, 0);

        // B yellow for a single sample.
        step(pat(3, 3), 1'b1);
        step(pat(3, 3), 1'b0);
        step(pat(3, 3), 1'b0);
        for (int i = 0; i < 6; i++) step(pat(3, 1), 1'b0);
        step(pat(3, 2), 1'b0);
        step(pat(3, 3), 1'b0);
        step(pat(3, 3), 1'b0);
        chk("timing_code", {5'd0, fault_code}, 5);
        chk("timing_grp", {7'd0, fault_grp}, 1);

        // B yellow held five samples.
        step(pat(3, 3), 1'b1);
`ifdef GRY_MON_FAULT_CNT_EN
        chk("fault_cnt_three", fault_cnt, 3);
`endif
        step(pat(3, 3), 1'b0);
        step(pat(3, 3), 1'b0);
        for (int i = 0; i < 6; i++) step(pat(3, 1), 1'b0);
        for (int i = 0; i < 5; i++) step(pat(3, 2), 1'b0);
        chk("stuck_not_yet", {7'd0, fault}, 0);
        step(pat(3, 2), 1'b0);
        chk("stuck_code", {5'd0, fault_code}, 6);
        chk("stuck_grp", {7'd0, fault_grp}, 1);

        // Clear coincident with a conflicting sample: that sample is dropped.
        step(pat(1, 1), 1'b1);
        step(pat(3, 3), 1'b0);
        step(pat(3, 3), 1'b0);
        step(pat(3, 3), 1'b0);
        chk("clear_drops_conflict", {7'd0, fault}, 0);

        // Randomized segments of legal stages, corrupted heads and clears.
        stage = 0;
        for (int seg = 0; seg < 80; seg++) begin
            len = $urandom_range(1, 8);
            case ($urandom_range(0, 7))
                0: p = 12'($urandom);
                1: begin p = stage_pat(stage); p[8:6] = lamp($urandom_range(1, 3)); end
                default: begin stage = (stage + 1) % 4; p = stage_pat(stage); end
            endcase
            for (int k = 0; k < len; k++) step(p, $urandom_range(0, 3) == 0);
        end

        // Asynchronous reset in the middle of a fault.
        step(pat(3, 3), m_fault);
        step(pat(1, 1), 1'b0);
        step(pat(3, 3), 1'b0);
        chk("pre_reset_fault", {7'd0, fault}, 1);
        #3 rstn = 1'b0;
        #1;
        chk("async_rst_fault", {7'd0, fault}, 0);
        chk("async_rst_code", {5'd0, fault_code}, 0);
        chk("async_rst_grp", {7'd0, fault_grp}, 0);
        chk("async_rst_all_red", {7'd0, all_red_req}, 0);
        chk("async_rst_phase", {4'd0, a_phase, b_phase}, 0);
`ifdef GRY_MON_FAULT_CNT_EN
        chk("async_rst_cnt", fault_cnt, 0);
`endif
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) step(stage_pat(0), 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/gry_conflict_monitor.md
Name: gry_conflict_monitor

Overview:
- Independent safety monitor on the 12 lamp drives (a0/a1/b0/b1 × green/yellow/red) produced by the 4-way traffic-light controller.
- Decodes each lamp head, checks pairing, cross-direction conflict, phase sequence and phase dwell times.
- Latches a sticky fault with a code and raises all_red_req so the top level can force all-red or flash.

Parameters:
- CNT_W, 5, width of the per-group dwell counters; counters saturate at 2^CNT_W-1.
- MIN_GREEN, 4, minimum legal green dwell in cycles.
- MIN_YELLOW, 2, minimum legal yellow dwell in cycles.
- MAX_YELLOW, 4, maximum legal yellow dwell in cycles.

Ports:
- clk  input  1  system clock, rising edge.
- rstn  input  1  asynchronous active-low reset.
- a0_green, a0_yellow, a0_red, a1_green, a1_yellow, a1_red  input  1 each  direction-A lamp drives.
- b0_green, b0_yellow, b0_red, b1_green, b1_yellow, b1_red  input  1 each  direction-B lamp drives.
- clr_fault  input  1  single-cycle fault clear request.
- a_phase  output  2  decoded phase of group A: 00 invalid, 01 G, 10 Y, 11 R.
- b_phase  output  2  decoded phase of group B, same encoding.
- fault  output  1  sticky fault flag.
- fault_code  output  3  cause of the latched fault.
- fault_grp  output  1  group at fault: 0 = A, 1 = B.
- all_red_req  output  1  force-all-red request.

Behaviour:
- One clock; reset is asynchronous and active-low.
- Reset values: every output 0; internal FSM = INIT; dwell counters = 0.
- Input capture:
  - All 12 lamp inputs are registered on every edge.
  - A pattern present before edge k is captured at edge k; a resulting fault is registered at edge k+1.
- Head decode:
  - Exactly one lamp lit gives G/Y/R; anything else is invalid.
  - Group phase is head 0's decoded phase, driven on a_phase/b_phase registered at edge k+1.
- Fault codes, in priority order (1 is highest). If several conditions hit in the same cycle, the lowest code wins.
  - 1 CONFLICT: A phase ≠ R and B phase ≠ R on the same sample. fault_grp = 0.
  - 2 LAMP: any head is invalid. fault_grp is the group of the lowest-numbered bad head, A before B.
  - 3 PAIR: head0 ≠ head1 within a group.
  - 4 SEQ: the group phase changed along an edge other than G→Y, Y→R or R→G.
  - 5 TIMING: the group leaves G with dwell < MIN_GREEN, or leaves Y with dwell < MIN_YELLOW.
  - 6 STUCK: the group is in Y with dwell > MAX_YELLOW.
- Dwell counter, per group:
  - Loads 1 on the first sample of a new phase, otherwise increments, saturating.
  - It is the count of the old phase that is compared at a transition.
- FSM:
  - INIT: the first sample after reset or clear. Only codes 1–3 are checked; counters load 1; then move to RUN, or to FAULT on a detection.
  - RUN: all checks active; any detection moves to FAULT.
  - FAULT: fault = 1, all_red_req = 1; fault_code and fault_grp are frozen to the first fault; further violations are ignored.
- Clear:
  - clr_fault in FAULT returns the FSM to INIT on the next edge and zeroes fault, fault_code, fault_grp and all_red_req.
  - A violation sampled in the same cycle as the clear is discarded; detection resumes from the next sample.
  - clr_fault in INIT or RUN is ignored.
- Reset mid-operation immediately returns to the reset values.
- The dwell counters keep running in FAULT, so a_phase/b_phase remain valid.

Optional Feature:
- Macro GRY_MON_FAULT_CNT_EN.
- Defined: adds output fault_cnt [7:0].
  - Increments, saturating at 255, on every INIT/RUN→FAULT entry.
  - Reset only by rstn; unaffected by clr_fault.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Legal cycle, 64 cycles: A G6/Y2/R8 with B mirrored (B R8 while A G/Y, then B G6/Y2) → fault stays 0; a_phase steps 01→10→11 one edge after the inputs.
- a0/a1 green and b0/b1 green in the same cycle → at edge k+1 fault = 1, fault_code = 1, all_red_req = 1; both stay 1 after the inputs return to legal.
- a0 green+yellow lit while A jumps G→R → fault_code = 2 (LAMP beats SEQ), fault_grp = 0.
- B yellow held for 1 cycle, defaults in force → fault_code = 5, fault_grp = 1; B yellow held 5 cycles → fault_code = 6 on the sample where dwell reaches 5.
- Latched fault, then clr_fault pulse with legal inputs → fault = 0 next edge and no re-fault; clr_fault coincident with a conflict → no fault from that sample.
- Under GRY_MON_FAULT_CNT_EN, three fault/clear sequences → fault_cnt = 3; assert rstn low mid-fault → all outputs 0 asynchronously and fault_cnt = 0.
